// File: rtl/div_unit.sv
// Iterative signed restoring divider: one quotient bit per clock, sign fix-up
// in a final cycle, then a one-cycle ready pulse with quotient/remainder/exception.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, abs_b;
  logic             sign_a, sign_b, exc;
  logic [WIDTH:0]   shifted, diff;
  logic             last_iter;

  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign busy      = (state != IDLE);

  // Trial subtraction on {rem, next dividend bit}; the top bit of diff is the borrow.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, abs_b};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_DIV) state_nxt = RUN;
      RUN:     if (ctrl_DIV) state_nxt = RUN;
               else if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = ctrl_DIV ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt            <= '0;
      rem            <= '0;
      quo            <= '0;
      abs_b          <= '0;
      sign_a         <= 1'b0;
      sign_b         <= 1'b0;
      exc            <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= (state == FIX);
      // Results are taken from the finished operation even if a new start lands on this edge.
      if (state == FIX) begin
        data_exception <= exc;
        data_result    <= exc ? '0 : ((sign_a ^ sign_b) ? -quo : quo);
        data_remainder <= exc ? '0 : (sign_a ? -rem : rem);
      end
      if (ctrl_DIV) begin
        sign_a <= data_operandA[WIDTH-1];
        sign_b <= data_operandB[WIDTH-1];
        quo    <= data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        abs_b  <= data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        exc    <= (data_operandB == '0) ||
                  ((data_operandA == MOST_NEG) && (data_operandB == '1));
        rem    <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        if (!diff[WIDTH]) begin
          rem <= diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= shifted[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, multi-cycle corner
// sequences (abort, reset, back-to-back) and random operands against a model.
module tb_div_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result, data_remainder;
  logic        data_exception, data_resultRDY, busy;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_remainder(data_remainder),
    .data_exception(data_exception), .data_resultRDY(data_resultRDY),
    .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a, b, q, r;
    logic        e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: signed arithmetic in 64 bits, C-style truncating division.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic e);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0 || (sa == -64'sd2147483648 && sb == -64'sd1)) begin
      q = '0; r = '0; e = 1'b1;
    end else begin
      lq = sa / sb;
      lr = sa % sb;
      q = lq[31:0]; r = lr[31:0]; e = 1'b0;
    end
  endfunction

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV = 1'b1;
    @(posedge clock);
    #1 ctrl_DIV = 1'b0;
  endtask

  // Ready is registered on the FIX edge E33 and sampled 1 ns later (k == 33).
  task automatic wait_result(input logic [31:0] eq, input logic [31:0] er,
                             input logic ee, input string name);
    int pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      data_operandA = $urandom;
      data_operandB = $urandom;
      @(posedge clock);
      #1;
      if (k == 1) check({name, " busy_running"}, 32'(busy), 32'd1);
      if (data_resultRDY) begin
        pulses++;
        check({name, " latency"}, 32'(k), 32'd33);
        check({name, " result"}, data_result, eq);
        check({name, " remainder"}, data_remainder, er);
        check({name, " exception"}, 32'(data_exception), 32'(ee));
        check({name, " busy_done"}, 32'(busy), 32'd0);
      end
    end
    check({name, " pulse_count"}, 32'(pulses), 32'd1);
    check({name, " hold_result"}, data_result, eq);
  endtask

  initial begin
    vec_t vecs[9];
    logic [31:0] q, r, a, b;
    logic e;
    int pulses;

    vecs[0] = '{32'd100,       32'd7,          32'd14,        32'd2,         1'b0};
    vecs[1] = '{32'hFFFFFF9C,  32'd7,          32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0};
    vecs[2] = '{32'd100,       32'hFFFFFFF9,   32'hFFFFFFF2,  32'd2,         1'b0};
    vecs[3] = '{32'd5,         32'd0,          32'd0,         32'd0,         1'b1};
    vecs[4] = '{32'h80000000,  32'hFFFFFFFF,   32'd0,         32'd0,         1'b1};
    vecs[5] = '{32'h80000000,  32'd1,          32'h80000000,  32'd0,         1'b0};
    vecs[6] = '{32'd0,         32'd5,          32'd0,         32'd0,         1'b0};
    vecs[7] = '{32'hFFFFFFF9,  32'hFFFFFFFE,   32'd3,         32'hFFFFFFFF,  1'b0};
    vecs[8] = '{32'h7FFFFFFF,  32'h80000000,   32'd0,         32'h7FFFFFFF,  1'b0};

    #1;
    check("reset result", data_result, 32'd0);
    check("reset remainder", data_remainder, 32'd0);
    check("reset exception", 32'(data_exception), 32'd0);
    check("reset ready", 32'(data_resultRDY), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      start(vecs[i].a, vecs[i].b);
      wait_result(vecs[i].q, vecs[i].r, vecs[i].e, $sformatf("vec%0d", i));
    end

    // Restart while busy: the first operation must never report.
    start(32'd1000, 32'd10);
    pulses = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clock);
      #1 if (data_resultRDY) pulses++;
    end
    check("abort early_pulse", 32'(pulses), 32'd0);
    start(32'd81, 32'd9);
    wait_result(32'd9, 32'd0, 1'b0, "abort");

    // Asynchronous reset mid-operation clears outputs and suppresses the pulse.
    start(32'd1000, 32'd10);
    repeat (14) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("rst_mid result", data_result, 32'd0);
    check("rst_mid remainder", data_remainder, 32'd0);
    check("rst_mid exception", 32'(data_exception), 32'd0);
    check("rst_mid busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1 if (data_resultRDY) pulses++;
    end
    check("rst_mid no_pulse", 32'(pulses), 32'd0);
    model(32'd12345, 32'd67, q, r, e);
    start(32'd12345, 32'd67);
    wait_result(q, r, e, "after_reset");

    // New start on the FIX edge of the running operation.
    start(32'd49, 32'd7);
    repeat (32) @(posedge clock);
    #1;
    start(32'd1000, 32'hFFFFFFFD);
    check("b2b first_ready", 32'(data_resultRDY), 32'd1);
    check("b2b first_result", data_result, 32'd7);
    check("b2b first_remainder", data_remainder, 32'd0);
    check("b2b busy_restarted", 32'(busy), 32'd1);
    model(32'd1000, 32'hFFFFFFFD, q, r, e);
    wait_result(q, r, e, "b2b second");

    for (int n = 0; n < 25; n++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = $urandom_range(1, 20);
        3: begin a = $urandom_range(0, 1000); b = $urandom; end
        default: b = $urandom;
      endcase
      model(a, b, q, r, e);
      start(a, b);
      wait_result(q, r, e, $sformatf("rand%0d a=%08h b=%08h", n, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
